// File: rtl/sdram_upload_reader.sv
// sdram_upload_reader
//   Serves host upload reads (16-bit halfwords) from SDRAM through a one-word
//   cache. When the host reads the upper half of the cached word, the next
//   word is prefetched.
//
// State table
//   state    | meaning
//   IDLE     | no request outstanding; cache hits are served here
//   FETCH    | demand read outstanding; host is stalled
//   PREFETCH | read of the next word outstanding; a host read may queue here
//   DRAIN    | upload ended with a request outstanding; discard its data
//
// Ports
//   clk1x        : sole clock, rising edge
//   reset        : synchronous, active-high
//   ioctl_upload : upload session active
//   ioctl_rd     : one-cycle host read strobe for ioctl_addr
//   ioctl_addr   : host byte address (bit 0 ignored)
//   ioctl_din    : halfword returned to the host
//   ioctl_wait   : host must stall while high
//   sdram_addr   : word-aligned SDRAM byte address (tag * 4 + BASE_ADDR)
//   sdram_req    : one-cycle read request pulse
//   sdram_rnw    : always 1 (read only)
//   sdram_dout   : SDRAM read data, valid with sdram_ready
//   sdram_ready  : one-cycle completion pulse
module sdram_upload_reader #(
  parameter logic [26:0] BASE_ADDR = 27'd0
) (
  input  logic        clk1x,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [26:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic [26:0] sdram_addr,
  output logic        sdram_req,
  output logic        sdram_rnw,
  input  logic [31:0] sdram_dout,
  input  logic        sdram_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, PREFETCH, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] cache_word, cache_word_n;
  logic [24:0] cache_tag, cache_tag_n;
  logic        cache_valid, cache_valid_n;
  logic [24:0] fetch_tag, fetch_tag_n;
  logic        fetch_half, fetch_half_n;
  logic        pend_rd, pend_rd_n;
  logic [24:0] pend_tag, pend_tag_n;
  logic        pend_half, pend_half_n;
  logic [15:0] din_n;
  logic        wait_n;
  logic [26:0] sdram_addr_n;
  logic        sdram_req_n;

  logic [24:0] rd_tag;
  logic        rd_half;
  logic        hit;
  logic [24:0] svc_tag;
  logic        svc_half;
  logic        unused_addr_bit0;

  assign rd_tag   = ioctl_addr[26:2];
  assign rd_half  = ioctl_addr[1];
  assign hit      = cache_valid && (cache_tag == rd_tag);
  // A read queued during PREFETCH takes priority over one arriving with ready.
  assign svc_tag  = pend_rd ? pend_tag  : rd_tag;
  assign svc_half = pend_rd ? pend_half : rd_half;
  assign unused_addr_bit0 = ioctl_addr[0];
  assign sdram_rnw = 1'b1;

  function automatic logic [26:0] word_addr(input logic [24:0] t);
    return {t, 2'b00} + BASE_ADDR;
  endfunction

  function automatic logic [15:0] sel_half(input logic [31:0] w, input logic h);
    return h ? w[31:16] : w[15:0];
  endfunction

  always_comb begin
    state_n       = state;
    cache_word_n  = cache_word;
    cache_tag_n   = cache_tag;
    cache_valid_n = cache_valid;
    fetch_tag_n   = fetch_tag;
    fetch_half_n  = fetch_half;
    pend_rd_n     = pend_rd;
    pend_tag_n    = pend_tag;
    pend_half_n   = pend_half;
    din_n         = ioctl_din;
    wait_n        = ioctl_wait;
    sdram_addr_n  = sdram_addr;
    sdram_req_n   = 1'b0;

    case (state)
      IDLE: begin
        if (!ioctl_upload) begin
          cache_valid_n = 1'b0;
        end else if (ioctl_rd) begin
          if (hit) begin
            din_n = sel_half(cache_word, rd_half);
            if (rd_half) begin
              sdram_req_n  = 1'b1;
              sdram_addr_n = word_addr(cache_tag + 25'd1);
              fetch_tag_n  = cache_tag + 25'd1;
              state_n      = PREFETCH;
            end
          end else begin
            sdram_req_n  = 1'b1;
            sdram_addr_n = word_addr(rd_tag);
            fetch_tag_n  = rd_tag;
            fetch_half_n = rd_half;
            wait_n       = 1'b1;
            state_n      = FETCH;
          end
        end
      end

      FETCH: begin
        if (!ioctl_upload) begin
          cache_valid_n = 1'b0;
          wait_n        = 1'b0;
          // A completion in this very cycle needs no draining.
          state_n       = sdram_ready ? IDLE : DRAIN;
        end else if (sdram_ready) begin
          cache_word_n  = sdram_dout;
          cache_tag_n   = fetch_tag;
          cache_valid_n = 1'b1;
          din_n         = sel_half(sdram_dout, fetch_half);
          wait_n        = 1'b0;
          state_n       = IDLE;
        end
      end

      PREFETCH: begin
        if (!ioctl_upload) begin
          cache_valid_n = 1'b0;
          wait_n        = 1'b0;
          pend_rd_n     = 1'b0;
          state_n       = sdram_ready ? IDLE : DRAIN;
        end else begin
          if (ioctl_rd && !pend_rd) begin
            pend_rd_n   = 1'b1;
            pend_tag_n  = rd_tag;
            pend_half_n = rd_half;
            wait_n      = 1'b1;
          end
          if (sdram_ready) begin
            cache_word_n  = sdram_dout;
            cache_tag_n   = fetch_tag;
            cache_valid_n = 1'b1;
            pend_rd_n     = 1'b0;
            state_n       = IDLE;
            if (pend_rd || ioctl_rd) begin
              if (svc_tag == fetch_tag) begin
                din_n  = sel_half(sdram_dout, svc_half);
                wait_n = 1'b0;
              end else begin
                sdram_req_n  = 1'b1;
                sdram_addr_n = word_addr(svc_tag);
                fetch_tag_n  = svc_tag;
                fetch_half_n = svc_half;
                wait_n       = 1'b1;
                state_n      = FETCH;
              end
            end
          end
        end
      end

      DRAIN: begin
        if (!ioctl_upload) cache_valid_n = 1'b0;
        if (sdram_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk1x) begin
    if (reset) begin
      state       <= IDLE;
      cache_word  <= 32'd0;
      cache_tag   <= 25'd0;
      cache_valid <= 1'b0;
      fetch_tag   <= 25'd0;
      fetch_half  <= 1'b0;
      pend_rd     <= 1'b0;
      pend_tag    <= 25'd0;
      pend_half   <= 1'b0;
      ioctl_din   <= 16'd0;
      ioctl_wait  <= 1'b0;
      sdram_addr  <= 27'd0;
      sdram_req   <= 1'b0;
    end else begin
      state       <= state_n;
      cache_word  <= cache_word_n;
      cache_tag   <= cache_tag_n;
      cache_valid <= cache_valid_n;
      fetch_tag   <= fetch_tag_n;
      fetch_half  <= fetch_half_n;
      pend_rd     <= pend_rd_n;
      pend_tag    <= pend_tag_n;
      pend_half   <= pend_half_n;
      ioctl_din   <= din_n;
      ioctl_wait  <= wait_n;
      sdram_addr  <= sdram_addr_n;
      sdram_req   <= sdram_req_n;
    end
  end

endmodule
